decode_cycle: RTL and testbench

//  RV32I decode stage: consumes InstrD/PCD/PCPlus4D from the fetch stage, decodes control,

---
 rtl/decode_cycle_if.sv | 59 +++++
 rtl/decode_cycle.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_cycle_if.sv
// ---------------------------------------------------------------------------
// decode_cycle_if
//   Bundles every non-clock signal of the decode stage: the fetch-side inputs
//   (InstrD/PCD/PCPlus4D), the writeback port into the register file, the
//   execute-stage flush, and the registered D->E pipeline outputs.
//
//   This is a plain pipeline boundary with no valid/ready handshake.
//   A new instruction is accepted on every rising clock edge. An all-zero
//   instruction word marks an empty slot, or bubble. FlushE squashes the slot
//   that is being loaded into E.
//
//   modport slave  : the decode stage itself
//   modport master : whoever drives fetch/writeback and consumes E outputs
// ---------------------------------------------------------------------------
interface decode_cycle_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  // writeback port
  logic            RegWriteW;
  logic [4:0]      RDW;
  logic [XLEN-1:0] ResultW;
  // hazard control
  logic            FlushE;
  // D->E pipeline register outputs
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            BranchE;
  logic            JumpE;
  logic            ALUSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [4:0]      Rs1_E;
  logic [4:0]      Rs2_E;
  logic [4:0]      RD_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic            IllegalE;

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, ALUSrcE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, Rs1_E, Rs2_E, RD_E,
           PCE, PCPlus4E, IllegalE
  );

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, ALUSrcE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, Rs1_E, Rs2_E, RD_E,
           PCE, PCPlus4E, IllegalE
  );
endinterface

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
//   RV32I decode stage, sitting between fetch and execute.
//   - The stage decodes the control signals for the subset
//     lw/sw/R-ALU/I-ALU/beq/jal.
//   - It owns the architectural register file. The writeback port writes
//     this file directly. When WB_BYPASS is set, a write and a read of the
//     same register in one cycle return the new value (write-through).
//   - It sign-extends the I/S/B/J immediates.
//   - All results are registered into the D->E pipeline register, so the
//     stage has a latency of one cycle.
//
// Ports
//   clk  : clock, all state on posedge
//   rst  : asynchronous, active-high. Clears the D->E register and all
//          registers of the register file.
//   bus  : decode_cycle_if.slave. Carries the fetch inputs, the writeback
//          port, FlushE and all *E outputs.
// ---------------------------------------------------------------------------
module decode_cycle #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst,
  decode_cycle_if.slave  bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam bit BYPASS = (WB_BYPASS != 0);

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_sel_t;

  // ------------------------------------------------------------------
  // Instruction fields
  // ------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_opcode = bus.InstrD[6:0];
  assign w_f3     = bus.InstrD[14:12];
  assign w_f7b5   = bus.InstrD[30];
  assign w_rs1    = bus.InstrD[19:15];
  assign w_rs2    = bus.InstrD[24:20];
  assign w_rd     = bus.InstrD[11:7];

  // ------------------------------------------------------------------
  // Register file. x0 is never stored, so the write side skips index 0.
  // The read side forces index 0 to zero.
  // ------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.RegWriteW && (bus.RDW != 5'd0)) begin
      r_regs[bus.RDW] <= bus.ResultW;
    end
  end

  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_rs1 != 5'd0) begin
      if (BYPASS && bus.RegWriteW && (bus.RDW == w_rs1)) w_rd1 = bus.ResultW;
      else                                               w_rd1 = r_regs[w_rs1];
    end
    if (w_rs2 != 5'd0) begin
      if (BYPASS && bus.RegWriteW && (bus.RDW == w_rs2)) w_rd2 = bus.ResultW;
      else                                               w_rd2 = r_regs[w_rs2];
    end
  end

  // ------------------------------------------------------------------
  // Control decode. Control signals are set only on the legal paths. An
  // illegal encoding therefore leaves every control signal at 0 and raises
  // w_illegal. The all-zero word is a bubble and is not illegal.
  // ------------------------------------------------------------------
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic       w_mem_write;
  logic       w_branch;
  logic       w_jump;
  logic       w_alu_src;
  logic [2:0] w_alu_ctl;
  logic       w_illegal;
  imm_sel_t   w_imm_sel;
  logic       w_alu_ok;
  logic [2:0] w_alu_op;

  // Shared function-3 decode for R-type and I-ALU. The sub encoding is
  // selected only for R-type with f7[5] set. addi always adds.
  always_comb begin
    w_alu_ok = 1'b1;
    w_alu_op = ALU_ADD;
    case (w_f3)
      3'b000: w_alu_op = ((w_opcode == OP_R) && w_f7b5) ? ALU_SUB : ALU_ADD;
      3'b010: w_alu_op = ALU_SLT;
      3'b110: w_alu_op = ALU_OR;
      3'b111: w_alu_op = ALU_AND;
      default: w_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_ctl    = ALU_ADD;
    w_illegal    = 1'b0;
    w_imm_sel    = IMM_NONE;
    case (w_opcode)
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
        w_imm_sel    = IMM_I;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_sel   = IMM_S;
      end
      OP_R: begin
        if (w_alu_ok) begin
          w_reg_write = 1'b1;
          w_alu_ctl   = w_alu_op;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_I: begin
        if (w_alu_ok) begin
          w_reg_write = 1'b1;
          w_alu_src   = 1'b1;
          w_alu_ctl   = w_alu_op;
          w_imm_sel   = IMM_I;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_BEQ: begin
        if (w_f3 == 3'b000) begin
          w_branch  = 1'b1;
          w_alu_ctl = ALU_SUB;
          w_imm_sel = IMM_B;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_result_src = 2'b10;
        w_imm_sel    = IMM_J;
      end
      default: begin
        w_illegal = (bus.InstrD != 32'h0);
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Immediate generation. All formats are sign-extended from InstrD[31].
  // ------------------------------------------------------------------
  logic [XLEN-1:0] w_imm;

  always_comb begin
    w_imm = '0;
    case (w_imm_sel)
      IMM_I: w_imm = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:20]};
      IMM_S: w_imm = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:25],
                      bus.InstrD[11:7]};
      IMM_B: w_imm = {{(XLEN-13){bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[7],
                      bus.InstrD[30:25], bus.InstrD[11:8], 1'b0};
      IMM_J: w_imm = {{(XLEN-21){bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[19:12],
                      bus.InstrD[20], bus.InstrD[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // D->E pipeline register. Both reset and flush load an all-zero slot,
  // including the data and index fields. Reset has priority over flush.
  // ------------------------------------------------------------------
  logic            r_reg_write_e;
  logic [1:0]      r_result_src_e;
  logic            r_mem_write_e;
  logic            r_branch_e;
  logic            r_jump_e;
  logic            r_alu_src_e;
  logic [2:0]      r_alu_ctl_e;
  logic [XLEN-1:0] r_rd1_e;
  logic [XLEN-1:0] r_rd2_e;
  logic [XLEN-1:0] r_imm_e;
  logic [4:0]      r_rs1_e;
  logic [4:0]      r_rs2_e;
  logic [4:0]      r_rd_e;
  logic [XLEN-1:0] r_pc_e;
  logic [XLEN-1:0] r_pc_plus4_e;
  logic            r_illegal_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.FlushE) begin
      r_reg_write_e  <= 1'b0;
      r_result_src_e <= 2'b00;
      r_mem_write_e  <= 1'b0;
      r_branch_e     <= 1'b0;
      r_jump_e       <= 1'b0;
      r_alu_src_e    <= 1'b0;
      r_alu_ctl_e    <= 3'b000;
      r_rd1_e        <= '0;
      r_rd2_e        <= '0;
      r_imm_e        <= '0;
      r_rs1_e        <= 5'd0;
      r_rs2_e        <= 5'd0;
      r_rd_e         <= 5'd0;
      r_pc_e         <= '0;
      r_pc_plus4_e   <= '0;
      r_illegal_e    <= 1'b0;
    end else begin
      r_reg_write_e  <= w_reg_write;
      r_result_src_e <= w_result_src;
      r_mem_write_e  <= w_mem_write;
      r_branch_e     <= w_branch;
      r_jump_e       <= w_jump;
      r_alu_src_e    <= w_alu_src;
      r_alu_ctl_e    <= w_alu_ctl;
      r_rd1_e        <= w_rd1;
      r_rd2_e        <= w_rd2;
      r_imm_e        <= w_imm;
      r_rs1_e        <= w_rs1;
      r_rs2_e        <= w_rs2;
      r_rd_e         <= w_rd;
      r_pc_e         <= bus.PCD;
      r_pc_plus4_e   <= bus.PCPlus4D;
      r_illegal_e    <= w_illegal;
    end
  end

  assign bus.RegWriteE   = r_reg_write_e;
  assign bus.ResultSrcE  = r_result_src_e;
  assign bus.MemWriteE   = r_mem_write_e;
  assign bus.BranchE     = r_branch_e;
  assign bus.JumpE       = r_jump_e;
  assign bus.ALUSrcE     = r_alu_src_e;
  assign bus.ALUControlE = r_alu_ctl_e;
  assign bus.RD1_E       = r_rd1_e;
  assign bus.RD2_E       = r_rd2_e;
  assign bus.Imm_Ext_E   = r_imm_e;
  assign bus.Rs1_E       = r_rs1_e;
  assign bus.Rs2_E       = r_rs2_e;
  assign bus.RD_E        = r_rd_e;
  assign bus.PCE         = r_pc_e;
  assign bus.PCPlus4E    = r_pc_plus4_e;
  assign bus.IllegalE    = r_illegal_e;

endmodule

// File: tb/tb_decode_cycle.sv
// ---------------------------------------------------------------------------
// tb_decode_cycle
//   This bench instantiates two copies of the decode stage: one with
//   write-through (WB_BYPASS=1) and one without (WB_BYPASS=0). Both copies
//   receive identical stimulus.
//   A table of directed instructions with hand-decoded expectations is run
//   right after reset, while every register is still zero. Hand-written
//   sequences then cover the writeback, flush and reset corner cases.
// ---------------------------------------------------------------------------
module tb_decode_cycle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_cycle_if bus1 ();
  decode_cycle_if bus0 ();

  decode_cycle #(.XLEN(32), .NUM_REGS(32), .WB_BYPASS(1)) u_dut_byp (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  decode_cycle #(.XLEN(32), .NUM_REGS(32), .WB_BYPASS(0)) u_dut_nobyp (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        flush;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw;
    logic        br;
    logic        jp;
    logic        asrc;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] instr, input logic flush,
                       input logic rw_w, input logic [4:0] rdw,
                       input logic [31:0] res_w, input logic [31:0] pc);
    bus1.InstrD = instr;  bus0.InstrD = instr;
    bus1.PCD = pc;        bus0.PCD = pc;
    bus1.PCPlus4D = pc + 32'd4;  bus0.PCPlus4D = pc + 32'd4;
    bus1.FlushE = flush;  bus0.FlushE = flush;
    bus1.RegWriteW = rw_w; bus0.RegWriteW = rw_w;
    bus1.RDW = rdw;       bus0.RDW = rdw;
    bus1.ResultW = res_w; bus0.ResultW = res_w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t v, input logic [31:0] pc);
    chk({v.name, ".RegWriteE"},   32'(bus1.RegWriteE),   32'(v.rw));
    chk({v.name, ".ResultSrcE"},  32'(bus1.ResultSrcE),  32'(v.rsrc));
    chk({v.name, ".MemWriteE"},   32'(bus1.MemWriteE),   32'(v.mw));
    chk({v.name, ".BranchE"},     32'(bus1.BranchE),     32'(v.br));
    chk({v.name, ".JumpE"},       32'(bus1.JumpE),       32'(v.jp));
    chk({v.name, ".ALUSrcE"},     32'(bus1.ALUSrcE),     32'(v.asrc));
    chk({v.name, ".ALUControlE"}, 32'(bus1.ALUControlE), 32'(v.alu));
    chk({v.name, ".Imm_Ext_E"},   bus1.Imm_Ext_E,        v.imm);
    chk({v.name, ".Rs1_E"},       32'(bus1.Rs1_E),       32'(v.rs1));
    chk({v.name, ".Rs2_E"},       32'(bus1.Rs2_E),       32'(v.rs2));
    chk({v.name, ".RD_E"},        32'(bus1.RD_E),        32'(v.rd));
    chk({v.name, ".IllegalE"},    32'(bus1.IllegalE),    32'(v.ill));
    chk({v.name, ".RD1_E"},       bus1.RD1_E,            32'h0);
    chk({v.name, ".RD2_E"},       bus1.RD2_E,            32'h0);
    chk({v.name, ".PCE"},         bus1.PCE,              v.flush ? 32'h0 : pc);
    chk({v.name, ".PCPlus4E"},    bus1.PCPlus4E,         v.flush ? 32'h0 : pc + 32'd4);
  endtask

  task automatic chk_all_zero(input string tag);
    vec_t z;
    z = '{tag, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000,
          32'h0, 5'd0, 5'd0, 5'd0, 1'b0};
    chk_vec(z, 32'h0);
    chk({tag, ".nobyp.RegWriteE"}, 32'(bus0.RegWriteE), 32'h0);
    chk({tag, ".nobyp.PCE"},       bus0.PCE,            32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    //        name       instr         fl rw rsrc   mw br jp as alu     imm           rs1 rs2 rd ill
    vecs.push_back('{"addi",   32'h00500093, 0, 1, 2'b00, 0, 0, 0, 1, 3'b000, 32'h00000005, 0,  5,  1,  0});
    vecs.push_back('{"beq",    32'hFE208CE3, 0, 0, 2'b00, 0, 1, 0, 0, 3'b001, 32'hFFFFFFF8, 1,  2,  25, 0});
    vecs.push_back('{"sw_fl",  32'h00512623, 1, 0, 2'b00, 0, 0, 0, 0, 3'b000, 32'h00000000, 0,  0,  0,  0});
    vecs.push_back('{"sw",     32'h00512623, 0, 0, 2'b00, 1, 0, 0, 1, 3'b000, 32'h0000000C, 2,  5,  12, 0});
    vecs.push_back('{"lw",     32'h00812303, 0, 1, 2'b01, 0, 0, 0, 1, 3'b000, 32'h00000008, 2,  8,  6,  0});
    vecs.push_back('{"sub",    32'h407302B3, 0, 1, 2'b00, 0, 0, 0, 0, 3'b001, 32'h00000000, 6,  7,  5,  0});
    vecs.push_back('{"and",    32'h003170B3, 0, 1, 2'b00, 0, 0, 0, 0, 3'b010, 32'h00000000, 2,  3,  1,  0});
    vecs.push_back('{"ori",    32'hFFF0E113, 0, 1, 2'b00, 0, 0, 0, 1, 3'b011, 32'hFFFFFFFF, 1,  31, 2,  0});
    vecs.push_back('{"slti",   32'h80022193, 0, 1, 2'b00, 0, 0, 0, 1, 3'b101, 32'hFFFFF800, 4,  0,  3,  0});
    vecs.push_back('{"jal",    32'h010000EF, 0, 1, 2'b10, 0, 0, 1, 0, 3'b000, 32'h00000010, 0,  16, 1,  0});
    vecs.push_back('{"jal_neg",32'hFFDFF06F, 0, 1, 2'b10, 0, 0, 1, 0, 3'b000, 32'hFFFFFFFC, 31, 29, 0,  0});
    vecs.push_back('{"bne_ill",32'hFE209CE3, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 32'h00000000, 1,  2,  25, 1});
    vecs.push_back('{"op7f",   32'h0000007F, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 32'h00000000, 0,  0,  0,  1});
    vecs.push_back('{"bubble", 32'h00000000, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 32'h00000000, 0,  0,  0,  0});

    // reset
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // table: drive, clock, compare the popped expectation
    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] pc;
      vec_t        v;
      pc = 32'h1000 + 32'(i * 16);
      drive(vecs[i].instr, vecs[i].flush, 1'b0, 5'd0, 32'h0, pc);
      exp_q.push_back(vecs[i]);
      tick();
      v = exp_q.pop_front();
      chk_vec(v, pc);
    end

    // same-cycle writeback of x3 while add x4,x3,x3 reads it
    drive(32'h00318233, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 32'h2000);
    tick();
    chk("wb_byp.RD1_E",   bus1.RD1_E, 32'hDEADBEEF);
    chk("wb_byp.RD2_E",   bus1.RD2_E, 32'hDEADBEEF);
    chk("wb_byp.ALUCtl",  32'(bus1.ALUControlE), 32'h0);
    chk("wb_nobyp.RD1_E", bus0.RD1_E, 32'h0);
    chk("wb_nobyp.RD2_E", bus0.RD2_E, 32'h0);
    drive(32'h00318233, 1'b0, 1'b0, 5'd0, 32'h0, 32'h2004);
    tick();
    chk("wb_commit.byp.RD1_E",   bus1.RD1_E, 32'hDEADBEEF);
    chk("wb_commit.nobyp.RD2_E", bus0.RD2_E, 32'hDEADBEEF);

    // writes to x0 are ignored: add x6,x0,x0
    drive(32'h00000333, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h2008);
    tick();
    chk("x0_same.RD1_E", bus1.RD1_E, 32'h0);
    drive(32'h00000333, 1'b0, 1'b0, 5'd0, 32'h0, 32'h200C);
    tick();
    chk("x0_after.RD1_E", bus1.RD1_E, 32'h0);
    chk("x0_after.RD2_E", bus0.RD2_E, 32'h0);

    // flush squashes E, but the writeback in the same cycle still commits
    drive(32'h00512623, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'h2010);
    tick();
    chk_all_zero("flush_wb");
    drive(32'h00038433, 1'b0, 1'b0, 5'd0, 32'h0, 32'h2014);
    tick();
    chk("flush_wb_commit.byp.RD1_E",   bus1.RD1_E, 32'h12345678);
    chk("flush_wb_commit.nobyp.RD1_E", bus0.RD1_E, 32'h12345678);
    chk("flush_wb_commit.RD_E",        32'(bus1.RD_E), 32'd8);

    // asynchronous reset mid-cycle drops the in-flight instruction
    drive(32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0, 32'h2018);
    tick();
    chk("pre_rst.RegWriteE", 32'(bus1.RegWriteE), 32'h1);
    drive(32'h00812303, 1'b0, 1'b0, 5'd0, 32'h0, 32'h201C);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(32'h00038433, 1'b0, 1'b0, 5'd0, 32'h0, 32'h2020);
    #1;
    chk_all_zero("post_rst_bubble");
    tick();
    chk("post_rst.RD1_E_cleared", bus1.RD1_E, 32'h0);
    chk("post_rst.nobyp.RD1_E",   bus0.RD1_E, 32'h0);
    chk("post_rst.RegWriteE",     32'(bus1.RegWriteE), 32'h1);
    chk("post_rst.PCE",           bus1.PCE, 32'h2020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
